dmem_bus_arbiter: RTL and testbench

DMEM_BUS_ARBITER -- requirements
Module: dmem_bus_arbiter

---
 rtl/dmem_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dmem_bus_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_arbiter.sv
// dmem_bus_arbiter: three-master (CPU, DMA, debug) arbiter for the data-memory bus.
// Registered one-hot grant, hold-limited ownership and an AND-OR slave-side mux.
// Build option DMEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise
// fixed priority is used (debug > CPU > DMA).
module dmem_bus_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  m_req,
  output logic [2:0]  m_grant,
  input  logic [23:0] m_addr,
  input  logic [2:0]  m_wr,
  input  logic [2:0]  m_rd,
  input  logic [23:0] m_wr_data,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wr_data,
  output logic        s_wr,
  output logic        s_rd,
  input  logic [7:0]  s_rd_data,
  output logic [7:0]  m_rd_data,
  output logic        busy
);

  typedef enum logic {IDLE, OWNED} state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] others;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  // Search starts at the pointer and wraps 2->0.
  function automatic logic [2:0] pick(input logic [2:0] cand, input logic [1:0] start);
    logic [2:0] win;
    win = 3'b000;
    case (start)
      2'd1: begin
        if (cand[1])      win = 3'b010;
        else if (cand[2]) win = 3'b100;
        else if (cand[0]) win = 3'b001;
      end
      2'd2: begin
        if (cand[2])      win = 3'b100;
        else if (cand[0]) win = 3'b001;
        else if (cand[1]) win = 3'b010;
      end
      default: begin
        if (cand[0])      win = 3'b001;
        else if (cand[1]) win = 3'b010;
        else if (cand[2]) win = 3'b100;
      end
    endcase
    return win;
  endfunction
`else
  // Fixed priority: debug beats CPU beats DMA.
  function automatic logic [2:0] pick(input logic [2:0] cand);
    logic [2:0] win;
    win = 3'b000;
    if (cand[2])      win = 3'b100;
    else if (cand[0]) win = 3'b001;
    else if (cand[1]) win = 3'b010;
    return win;
  endfunction
`endif

  // State, grant, hold counter (and pointer) registers; reset aborts ownership at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      hold_q  <= 8'd0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      ptr_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Next-state: arbitrate from idle, re-arbitrate when the owner leaves, rotate at hold limit.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    others  = m_req & ~grant_q;
    case (state_q)
      IDLE: begin
        hold_d = 8'd0;
        if (m_req != 3'b000) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          grant_d = pick(m_req, ptr_q);
`else
          grant_d = pick(m_req);
`endif
          state_d = OWNED;
        end
      end
      OWNED: begin
        if ((m_req & grant_q) == 3'b000) begin
          // Owner released; the remaining requesters compete at this same edge.
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          grant_d = pick(m_req, ptr_q);
`else
          grant_d = pick(m_req);
`endif
          state_d = (m_req != 3'b000) ? OWNED : IDLE;
          hold_d  = 8'd0;
        end else if ((hold_q >= HOLD_LIMIT) && (others != 3'b000)) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          grant_d = pick(others, ptr_q);
`else
          grant_d = pick(others);
`endif
          hold_d  = 8'd0;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
        hold_d  = 8'd0;
      end
    endcase
  end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Pointer tracks the index just after the most recently granted master.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_d != grant_q) begin
      case (grant_d)
        3'b001:  ptr_d = 2'd1;
        3'b010:  ptr_d = 2'd2;
        3'b100:  ptr_d = 2'd0;
        default: ptr_d = ptr_q;
      endcase
    end
  end
`endif

  // AND-OR slave mux: only the granted master's lanes and strobes reach the slave.
  always_comb begin
    s_addr    = 8'd0;
    s_wr_data = 8'd0;
    s_wr      = 1'b0;
    s_rd      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_addr    = s_addr    | ({8{grant_q[i]}} & m_addr[8*i +: 8]);
      s_wr_data = s_wr_data | ({8{grant_q[i]}} & m_wr_data[8*i +: 8]);
      s_wr      = s_wr      | (grant_q[i] & m_wr[i]);
      s_rd      = s_rd      | (grant_q[i] & m_rd[i]);
    end
  end

  assign m_grant   = grant_q;
  assign busy      = |grant_q;
  assign m_rd_data = s_rd_data;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// tb_dmem_bus_arbiter: scoreboard bench for dmem_bus_arbiter (MAX_HOLD = 8).
// Follows DMEM_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_dmem_bus_arbiter;

  localparam int MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  mReq = '0;
  logic [2:0]  mGrant;
  logic [23:0] mAddr = '0;
  logic [2:0]  mWr = '0;
  logic [2:0]  mRd = '0;
  logic [23:0] mWrData = '0;
  logic [7:0]  sAddr;
  logic [7:0]  sWrData;
  logic        sWr;
  logic        sRd;
  logic [7:0]  sRdData = '0;
  logic [7:0]  mRdData;
  logic        busy;

  int vectorCount = 0;
  int missCount   = 0;

  logic [2:0] expGrantQ[$];
  logic [2:0] modelGrant = '0;
  logic [7:0] modelHold  = '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  int modelPtr = 0;
`endif

  dmem_bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .m_req(mReq), .m_grant(mGrant), .m_addr(mAddr),
    .m_wr(mWr), .m_rd(mRd), .m_wr_data(mWrData), .s_addr(sAddr),
    .s_wr_data(sWrData), .s_wr(sWr), .s_rd(sRd), .s_rd_data(sRdData),
    .m_rd_data(mRdData), .busy(busy)
  );

  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference arbitration choice, walking candidates in policy order.
  function automatic logic [2:0] pickModel(input logic [2:0] cand);
    int order[3];
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 3; k++) order[k] = (modelPtr + k) % 3;
`else
    order = '{2, 0, 1};
`endif
    for (int k = 0; k < 3; k++)
      if (cand[order[k]]) return 3'(1 << order[k]);
    return 3'b000;
  endfunction

  task automatic modelStep(input logic [2:0] req);
    logic [2:0] nextGrant;
    nextGrant = modelGrant;
    if (modelGrant == 3'b000)
      nextGrant = pickModel(req);
    else if ((req & modelGrant) == 3'b000)
      nextGrant = pickModel(req);
    else if (int'(modelHold) >= MAX_HOLD - 1 && (req & ~modelGrant) != 3'b000)
      nextGrant = pickModel(req & ~modelGrant);
    if (nextGrant != modelGrant) begin
      modelHold = 8'd0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      for (int i = 0; i < 3; i++) if (nextGrant[i]) modelPtr = (i + 1) % 3;
`endif
    end else if (modelGrant != 3'b000 && modelHold != 8'hFF) begin
      modelHold = modelHold + 8'd1;
    end
    modelGrant = nextGrant;
  endtask

  task automatic modelReset();
    modelGrant = 3'b000;
    modelHold  = 8'd0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    modelPtr   = 0;
`endif
    expGrantQ.delete();
  endtask

  // Drive one cycle of stimulus, push the expected grant, then compare after the edge.
  task automatic applyStimulus(input logic [2:0] req, input logic [2:0] wr, input logic [2:0] rd,
                               input logic [23:0] addr, input logic [23:0] wdata);
    logic [2:0] expGrant;
    logic [7:0] expAddr, expData;
    logic       expWr, expRd;
    @(negedge clk);
    mReq = req; mWr = wr; mRd = rd; mAddr = addr; mWrData = wdata;
    sRdData = 8'($urandom);
    modelStep(req);
    expGrantQ.push_back(modelGrant);
    @(posedge clk);
    #1;
    if (expGrantQ.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    expGrant = expGrantQ.pop_front();
    expAddr = 8'd0; expData = 8'd0; expWr = 1'b0; expRd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (expGrant[i]) begin
        expAddr = addr[8*i +: 8];
        expData = wdata[8*i +: 8];
        expWr   = wr[i];
        expRd   = rd[i];
      end
    end
    checkOutput("grant", 32'(mGrant), 32'(expGrant));
    checkOutput("busy", 32'(busy), 32'(expGrant != 3'b000));
    checkOutput("s_addr", 32'(sAddr), 32'(expAddr));
    checkOutput("s_wr_data", 32'(sWrData), 32'(expData));
    checkOutput("s_wr", 32'(sWr), 32'(expWr));
    checkOutput("s_rd", 32'(sRd), 32'(expRd));
    checkOutput("m_rd_data", 32'(mRdData), 32'(sRdData));
  endtask

  initial begin
    $display("[TB] starting dmem_bus_arbiter bench");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_grant", 32'(mGrant), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_s_addr", 32'(sAddr), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();

    // Single CPU request, then release.
    applyStimulus(3'b001, 3'b001, 3'b000, 24'h332212, 24'h00A5C3);
    checkOutput("cpu_first_grant", 32'(mGrant), 32'h1);
    applyStimulus(3'b001, 3'b000, 3'b001, 24'h332212, 24'h00A5C3);
    applyStimulus(3'b000, 3'b000, 3'b000, 24'h332212, 24'h00A5C3);
    checkOutput("cpu_release", 32'(mGrant), 32'h0);

    // CPU owns while DMA waits: DMA strobes and address must be blocked; hold limit forces rotation.
    applyStimulus(3'b001, 3'b000, 3'b000, 24'h448044, 24'h0000EE);
    for (int c = 0; c < 2 * MAX_HOLD + 2; c++)
      applyStimulus(3'b011, 3'b010, 3'b000, 24'h448044, 24'h00BB11);
    applyStimulus(3'b000, 3'b000, 3'b000, 24'h0, 24'h0);

    // Two requesters from idle, then all three with the hold limit deciding rotation.
    applyStimulus(3'b011, 3'b000, 3'b000, 24'h030201, 24'h0);
    for (int c = 0; c < 3 * MAX_HOLD; c++)
      applyStimulus(3'b111, 3'b111, 3'b111, 24'h030201, 24'h0C0B0A);
    applyStimulus(3'b110, 3'b000, 3'b000, 24'h030201, 24'h0);
    applyStimulus(3'b000, 3'b000, 3'b000, 24'h0, 24'h0);

    // Random traffic.
    for (int c = 0; c < 60; c++)
      applyStimulus(3'($urandom), 3'($urandom), 3'($urandom), 24'($urandom), 24'($urandom));

    // Asynchronous reset between edges while a master owns the bus.
    applyStimulus(3'b100, 3'b000, 3'b000, 24'h0, 24'h0);
    applyStimulus(3'b100, 3'b000, 3'b000, 24'h0, 24'h0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_grant", 32'(mGrant), 32'h0);
    checkOutput("async_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    applyStimulus(3'b010, 3'b000, 3'b010, 24'h00EE00, 24'h0);
    checkOutput("post_rst_grant", 32'(mGrant), 32'h2);
    applyStimulus(3'b000, 3'b000, 3'b000, 24'h0, 24'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
